led_fifo_reader: RTL and testbench
==================================

Name: led_fifo_reader

Overview:
- Read-side consumer of the LED backlight FIFO. It pops per-zone brightness words from the FIFO read port using the standard registered-read handshake: no first-word fall-through, data valid one cycle after the read enable.
- Each word is serialized MSB-first onto a 3-wire LED driver interface (SCLK/SDO/LATCH).
- After ZONES words it issues one latch pulse per frame.
- It sits between the local-dimming zone FIFO and the board LED driver pins.

Parameters:
- DATA_WIDTH, 16, width of one zone brightness word; equals the FIFO read data width.
- ZONES, 64, words per frame before the latch; legal 1..1024.
- CLK_DIV, 2, clk cycles per SCLK half-period; legal 1..255.
- LATCH_CYCLES, 4, width of the led_latch pulse in clk cycles; legal 1..255.

Ports:
- clk, input, 1, single system clock. The FIFO read side runs on this clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, one-cycle pulse that arms transmission of one frame.
- fifo_rd_data, input, DATA_WIDTH, FIFO read data; valid the cycle after fifo_rd_en=1.
- fifo_rd_empty, input, 1, FIFO empty flag.
- fifo_rd_en, output, 1, FIFO read enable.
- led_sclk, output, 1, serial clock to the LED driver; idles low.
- led_sdo, output, 1, serial data, MSB first.
- led_latch, output, 1, active-high latch pulse after the last zone.
- busy, output, 1, high from leaving IDLE until returning to IDLE.
- zone_cnt, output, 10, index of the zone currently being sent.
- underrun, output, 1, sticky flag: the FIFO was empty mid-frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs are 0.
  - FSM=IDLE.
  - armed=0, pending=0, shift register=0, div counter=0, bit counter=0.
- Release is synchronous to clk, taking effect on the first edge with rst_n=1.
- FSM states: IDLE, REQ, CAP, SHIFT, WAIT, LATCH.
- IDLE:
  - frame_start sets armed.
  - If armed and !fifo_rd_empty, go to REQ.
  - underrun clears on frame_start taken in IDLE.
- REQ:
  - fifo_rd_en=1 for exactly this one cycle, then go to CAP.
  - fifo_rd_en is never asserted when fifo_rd_empty=1.
- CAP:
  - Load the shift register from fifo_rd_data.
  - div=0, bit=0, then go to SHIFT.
- SHIFT:
  - div counts 0..2*CLK_DIV-1.
  - led_sdo = shift register MSB, updated only when div=0; it is therefore stable while led_sclk is high.
  - led_sclk = 1 when div >= CLK_DIV.
  - At div=2*CLK_DIV-1: shift left by 1 and increment bit.
  - After bit DATA_WIDTH-1 completes:
    - If zone_cnt=ZONES-1, go to LATCH.
    - Otherwise increment zone_cnt, then go to REQ if !fifo_rd_empty, else WAIT.
  - One word costs 2 + 2*CLK_DIV*DATA_WIDTH cycles (REQ+CAP overhead).
- WAIT:
  - led_sclk=0, led_sdo holds its last value, underrun<=1.
  - Go to REQ when !fifo_rd_empty.
  - The frame resumes with no lost or duplicated word.
- LATCH:
  - led_latch=1 for LATCH_CYCLES cycles, with led_sclk=0 and led_sdo=0.
  - Then zone_cnt=0, armed=0.
  - If pending=1: armed=1, pending=0.
  - Go to IDLE.
- frame_start while busy:
  - Sets pending; depth is one, so extra pulses are dropped.
  - Never aborts the current frame.
- frame_start in the same cycle LATCH exits: pending is set and consumed at that exit.
- fifo_rd_empty rising during CAP: no effect; the word was already popped.
- Reset mid-frame: immediate return to the reset state. The FIFO contents are untouched by this block.
- zone_cnt wraps only via the LATCH reset, never by overflow.

Test Plan:
1. Basic frame (DATA_WIDTH=16, ZONES=2, CLK_DIV=2):
   - Stimulus: preload 0xA5F0, 0x0001; pulse frame_start.
   - Required: exactly 2 fifo_rd_en pulses.
   - Required: SDO bits 1010010111110000 then 0000000000000001, sampled on SCLK rising edges.
   - Required: SCLK period 4 cycles; 32 rising edges; led_latch high 4 cycles; busy falls after the latch.
2. Timing:
   - Required: first SCLK rising edge 5 cycles after REQ.
   - Required: word 2 REQ exactly 1 cycle after the last SCLK falling period of word 1 ends.
   - Required: SDO never changes while SCLK=1.
3. Underrun:
   - Stimulus: ZONES=3, preload 1 word; push word 2 after 100 idle cycles, then word 3.
   - Required: WAIT entered with SCLK low; underrun=1 and stays 1.
   - Required: all 3 words are sent in order with one latch.
   - Required: the next frame_start in IDLE clears underrun.
4. No arm:
   - Stimulus: FIFO non-empty, no frame_start.
   - Required: fifo_rd_en stays 0 and busy=0 indefinitely.
   - Stimulus: FIFO empty with frame_start.
   - Required: no rd_en until the first write arrives.
5. Pending frame:
   - Stimulus: two frame_start pulses during frame 1, with 2*ZONES words queued.
   - Required: frame 2 starts immediately after latch 1 with no extra frame_start.
   - Required: a third pulse is dropped, giving exactly 2 latches.
6. Reset mid-frame:
   - Stimulus: rst_n=0 asserted while SCLK=1 at zone 1 bit 7.
   - Required: all outputs 0 asynchronously, before the next clk edge.
   - Required: after release and frame_start, transmission restarts at zone 0 with the next FIFO word.

Source files
------------

// File: rtl/led_fifo_reader.sv
// led_fifo_reader
//
// Read-side consumer of the LED backlight zone FIFO. When a frame is armed it
// pops one brightness word per zone through the FIFO's registered-read port.
// The word is valid the cycle after fifo_rd_en. Each word is shifted out MSB
// first on a three-wire LED driver interface. After the last zone of the frame
// a single latch pulse is issued.
//
// Parameters:
//   DATA_WIDTH   - bits per zone word (matches the FIFO read width)
//   ZONES        - words per frame before the latch pulse (1..1024)
//   CLK_DIV      - clk cycles per SCLK half-period (1..255)
//   LATCH_CYCLES - width of the led_latch pulse in clk cycles (1..255)
//
// Ports:
//   clk           - system clock; the FIFO read side shares it
//   rst_n         - asynchronous active-low reset
//   frame_start   - one-cycle pulse arming one frame
//   fifo_rd_data  - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty - FIFO empty flag
//   fifo_rd_en    - FIFO read enable, one cycle per word
//   led_sclk      - serial clock to the driver, idles low
//   led_sdo       - serial data, MSB first, stable while led_sclk is high
//   led_latch     - active-high latch pulse after the last zone
//   busy          - high while a frame is in progress
//   zone_cnt      - index of the zone currently being sent
//   underrun      - sticky: the FIFO ran dry in the middle of a frame

module led_fifo_reader #(
    parameter int DATA_WIDTH   = 16,
    parameter int ZONES        = 64,
    parameter int CLK_DIV      = 2,
    parameter int LATCH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  fifo_rd_en,
    output logic                  led_sclk,
    output logic                  led_sdo,
    output logic                  led_latch,
    output logic                  busy,
    output logic [9:0]            zone_cnt,
    output logic                  underrun
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [9:0]       ZONE_LAST = 10'(ZONES - 1);
    localparam logic [7:0]       LATCH_END = 8'(LATCH_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAP,
        ST_SHIFT,
        ST_WAIT,
        ST_LATCH
    } state_t;

    state_t                state;
    logic                  armed;
    logic                  pending;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [7:0]            latch_cnt;

    // Frame sequencer. Every output is a register.
    // fifo_rd_en is set on the edge that enters REQ, so it lines up exactly
    // with the REQ cycle, and the word is then captured in CAP.
    // led_sclk and led_sdo are computed from the divider value of the current
    // cycle, so on the pins they trail the divider by one clk. led_sdo moves
    // only on the div=0 cycle, so it has already settled a full half-period
    // before led_sclk rises. Entering LATCH lets the last SCLK high cycle
    // finish first. led_latch therefore starts one cycle into LATCH, which is
    // why LATCH lasts LATCH_CYCLES+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            pending    <= 1'b0;
            shift_reg  <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            latch_cnt  <= '0;
            fifo_rd_en <= 1'b0;
            led_sclk   <= 1'b0;
            led_sdo    <= 1'b0;
            led_latch  <= 1'b0;
            busy       <= 1'b0;
            zone_cnt   <= '0;
            underrun   <= 1'b0;
        end else begin
            // A start request during a frame is held, one deep, for the latch exit.
            if (frame_start && state != ST_IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        armed    <= 1'b1;
                        underrun <= 1'b0;
                    end
                    if (armed && !fifo_rd_empty) begin
                        state      <= ST_REQ;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ST_REQ: begin
                    fifo_rd_en <= 1'b0;
                    led_sclk   <= 1'b0;
                    state      <= ST_CAP;
                end

                ST_CAP: begin
                    shift_reg <= fifo_rd_data;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    led_sclk  <= 1'b0;
                    state     <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    led_sclk <= (div_cnt >= DIV_HALF);
                    if (div_cnt == '0) begin
                        led_sdo <= shift_reg[DATA_WIDTH-1];
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
                            if (zone_cnt == ZONE_LAST) begin
                                latch_cnt <= '0;
                                state     <= ST_LATCH;
                            end else begin
                                zone_cnt <= zone_cnt + 10'd1;
                                if (!fifo_rd_empty) begin
                                    fifo_rd_en <= 1'b1;
                                    state      <= ST_REQ;
                                end else begin
                                    state <= ST_WAIT;
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                ST_WAIT: begin
                    led_sclk <= 1'b0;
                    underrun <= 1'b1;
                    if (!fifo_rd_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= ST_REQ;
                    end
                end

                ST_LATCH: begin
                    led_sclk <= 1'b0;
                    led_sdo  <= 1'b0;
                    if (latch_cnt == LATCH_END) begin
                        led_latch <= 1'b0;
                        latch_cnt <= '0;
                        zone_cnt  <= '0;
                        busy      <= 1'b0;
                        // A request that arrives on this very cycle is taken
                        // here as well, instead of being parked in pending.
                        armed     <= pending | frame_start;
                        pending   <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        led_latch <= 1'b1;
                        latch_cnt <= latch_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_fifo_reader.sv
// tb_led_fifo_reader
//
// Directed bench for led_fifo_reader.
// The DUT is configured with DATA_WIDTH=16, ZONES=3, CLK_DIV=2 and
// LATCH_CYCLES=4. A behavioural registered-read FIFO feeds the DUT.
// A negedge monitor records read strobes, SCLK rising edges with the SDO bit
// sampled there, and latch pulses. The stimulus compares these records
// against hand-computed values.

module tb_led_fifo_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] fifo_rd_data = '0;
    logic        fifo_rd_empty;
    logic        fifo_rd_en;
    logic        led_sclk;
    logic        led_sdo;
    logic        led_latch;
    logic        busy;
    logic [9:0]  zone_cnt;
    logic        underrun;

    int tests = 0;
    int fails = 0;

    led_fifo_reader #(
        .DATA_WIDTH  (16),
        .ZONES       (3),
        .CLK_DIV     (2),
        .LATCH_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_en   (fifo_rd_en),
        .led_sclk     (led_sclk),
        .led_sdo      (led_sdo),
        .led_latch    (led_latch),
        .busy         (busy),
        .zone_cnt     (zone_cnt),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // FIFO with a registered read port. Only the stimulus writes, and only
    // the read process pops, so the two pointers never share a writer.
    logic [15:0] wr_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign fifo_rd_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_rd_data <= wr_mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Negedge monitor: records read strobes, SCLK rising edges with the SDO
    // bit seen there, latch pulses, and protocol violations.
    int   cyc = 0;
    int   rd_times[$];
    int   rise_times[$];
    logic sdo_bits[$];
    int   latch_fall_times[$];
    int   latch_rises = 0;
    int   latch_hi = 0;
    int   sdo_viol = 0;
    int   rd_empty_viol = 0;
    int   latch_nobusy = 0;
    logic prev_sclk = 1'b0;
    logic prev_sdo = 1'b0;
    logic prev_latch = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (fifo_rd_en) begin
            rd_times.push_back(cyc);
            if (fifo_rd_empty) rd_empty_viol = rd_empty_viol + 1;
        end
        if (led_sclk && !prev_sclk) begin
            rise_times.push_back(cyc);
            sdo_bits.push_back(led_sdo);
        end
        if (led_sclk && prev_sclk && (led_sdo != prev_sdo)) sdo_viol = sdo_viol + 1;
        if (led_latch) begin
            latch_hi = latch_hi + 1;
            if (!busy) latch_nobusy = latch_nobusy + 1;
        end
        if (led_latch && !prev_latch) latch_rises = latch_rises + 1;
        if (!led_latch && prev_latch) latch_fall_times.push_back(cyc);
        prev_sclk  = led_sclk;
        prev_sdo   = led_sdo;
        prev_latch = led_latch;
    end

    function automatic int rd_at(input int i);
        return (i < rd_times.size()) ? rd_times[i] : -1000;
    endfunction

    function automatic int rise_at(input int i);
        return (i < rise_times.size()) ? rise_times[i] : -1000;
    endfunction

    function automatic int fall_at(input int i);
        return (i < latch_fall_times.size()) ? latch_fall_times[i] : -1000;
    endfunction

    // Rebuild one 16-bit word from the SDO bits sampled on SCLK rising edges.
    function automatic logic [15:0] get_word(input int base);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            if (base + i < sdo_bits.size()) w = {w[14:0], sdo_bits[base + i]};
            else w = {w[14:0], 1'b0};
        end
        return w;
    endfunction

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests = tests + 1;
        if (got !== want) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Two cycles of stimulus: optionally push a word, optionally pulse frame_start.
    task automatic applyStimulus(input logic do_push, input logic [15:0] word, input logic do_start);
        @(negedge clk);
        #1;
        if (do_push) begin
            wr_mem[wr_ptr % 256] = word;
            wr_ptr = wr_ptr + 1;
        end
        frame_start = do_start;
        @(negedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    // Wait until n more latch pulses have been seen and the block is idle.
    task automatic wait_frame(input int base, input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (!((latch_rises >= base + n) && !busy) && (k < budget)) begin
            @(negedge clk);
            #1;
            k++;
        end
        checkOutput(tag, 32'(k < budget), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int rb, bb, rsb, lb, lh, fb, bad, k;

    initial begin
        // Reset state
        rst_n = 1'b0;
        wait_cycles(3);
        checkOutput("reset_outputs",
                    32'({fifo_rd_en, led_sclk, led_sdo, led_latch, busy, underrun, zone_cnt}), 32'd0);
        rst_n = 1'b1;
        wait_cycles(2);
        checkOutput("idle_after_release", 32'({busy, fifo_rd_en}), 32'd0);

        // Basic frame: three zone words, then one latch
        rb = rd_times.size(); bb = sdo_bits.size(); rsb = rise_times.size();
        lb = latch_rises; lh = latch_hi;
        applyStimulus(1'b1, 16'hA5F0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b0);
        applyStimulus(1'b1, 16'h8000, 1'b1);
        wait_frame(lb, 1, 600, "t1_frame_done");
        checkOutput("t1_rd_pulses", 32'(rd_times.size() - rb), 32'd3);
        checkOutput("t1_sclk_rises", 32'(rise_times.size() - rsb), 32'd48);
        checkOutput("t1_word0", 32'(get_word(bb)), 32'h0000A5F0);
        checkOutput("t1_word1", 32'(get_word(bb + 16)), 32'h00000001);
        checkOutput("t1_word2", 32'(get_word(bb + 32)), 32'h00008000);
        bad = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 1; i < 16; i++) begin
                if (rise_at(rsb + 16 * w + i) - rise_at(rsb + 16 * w + i - 1) != 4) bad++;
            end
        end
        checkOutput("t1_sclk_period", 32'(bad), 32'd0);
        checkOutput("t1_latch_pulses", 32'(latch_rises - lb), 32'd1);
        checkOutput("t1_latch_width", 32'(latch_hi - lh), 32'd4);
        checkOutput("t1_busy_low", 32'(busy), 32'd0);

        // Timing relative to the read strobe
        checkOutput("t2_first_rise", 32'(rise_at(rsb) - rd_at(rb)), 32'd5);
        checkOutput("t2_word_gap", 32'(rd_at(rb + 1) - rd_at(rb)), 32'd66);
        checkOutput("t2_req_after_last_rise", 32'(rd_at(rb + 1) - rise_at(rsb + 15)), 32'd1);

        // Underrun: one word queued, the rest arrive late
        rb = rd_times.size(); bb = sdo_bits.size(); lb = latch_rises;
        applyStimulus(1'b1, 16'h1234, 1'b1);
        wait_cycles(110);
        checkOutput("t3_underrun_set", 32'(underrun), 32'd1);
        checkOutput("t3_wait_sclk_low", 32'(led_sclk), 32'd0);
        checkOutput("t3_wait_busy", 32'(busy), 32'd1);
        checkOutput("t3_wait_zone", 32'(zone_cnt), 32'd1);
        checkOutput("t3_wait_reads", 32'(rd_times.size() - rb), 32'd1);
        applyStimulus(1'b1, 16'h5678, 1'b0);
        wait_cycles(10);
        applyStimulus(1'b1, 16'h9ABC, 1'b0);
        checkOutput("t3_underrun_sticky", 32'(underrun), 32'd1);
        wait_frame(lb, 1, 600, "t3_frame_done");
        checkOutput("t3_word0", 32'(get_word(bb)), 32'h00001234);
        checkOutput("t3_word1", 32'(get_word(bb + 16)), 32'h00005678);
        checkOutput("t3_word2", 32'(get_word(bb + 32)), 32'h00009ABC);
        checkOutput("t3_latch_pulses", 32'(latch_rises - lb), 32'd1);
        checkOutput("t3_rd_pulses", 32'(rd_times.size() - rb), 32'd3);
        checkOutput("t3_underrun_after", 32'(underrun), 32'd1);
        checkOutput("t3_zone_reset", 32'(zone_cnt), 32'd0);

        // Start with an empty FIFO: underrun clears, no read until data arrives
        rb = rd_times.size(); bb = sdo_bits.size(); lb = latch_rises;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        wait_cycles(2);
        checkOutput("t4_underrun_cleared", 32'(underrun), 32'd0);
        wait_cycles(50);
        checkOutput("t4_empty_no_rd", 32'(rd_times.size() - rb), 32'd0);
        checkOutput("t4_empty_not_busy", 32'(busy), 32'd0);
        applyStimulus(1'b1, 16'hC3C3, 1'b0);
        wait_cycles(3);
        checkOutput("t4_rd_on_write", 32'(rd_times.size() - rb), 32'd1);
        checkOutput("t4_busy_on_write", 32'(busy), 32'd1);
        applyStimulus(1'b1, 16'h3C3C, 1'b0);
        applyStimulus(1'b1, 16'h0FF0, 1'b0);
        wait_frame(lb, 1, 600, "t4_frame_done");
        checkOutput("t4_word0", 32'(get_word(bb)), 32'h0000C3C3);
        checkOutput("t4_word2", 32'(get_word(bb + 32)), 32'h00000FF0);
        checkOutput("t4_no_underrun", 32'(underrun), 32'd0);

        // No arm: data present but no frame_start
        rb = rd_times.size();
        applyStimulus(1'b1, 16'h0F0F, 1'b0);
        wait_cycles(50);
        checkOutput("t4_noarm_no_rd", 32'(rd_times.size() - rb), 32'd0);
        checkOutput("t4_noarm_busy", 32'(busy), 32'd0);

        // Pending frame: three pulses, two frames' worth of words queued
        rb = rd_times.size(); bb = sdo_bits.size(); lb = latch_rises;
        lh = latch_hi; fb = latch_fall_times.size();
        applyStimulus(1'b1, 16'h1001, 1'b0);
        applyStimulus(1'b1, 16'h1002, 1'b0);
        applyStimulus(1'b1, 16'h1003, 1'b0);
        applyStimulus(1'b1, 16'h1004, 1'b0);
        applyStimulus(1'b1, 16'h1005, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        wait_cycles(20);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        wait_cycles(20);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        wait_frame(lb, 2, 1500, "t5_frames_done");
        checkOutput("t5_latch_pulses", 32'(latch_rises - lb), 32'd2);
        checkOutput("t5_rd_pulses", 32'(rd_times.size() - rb), 32'd6);
        checkOutput("t5_f1_word0", 32'(get_word(bb)), 32'h00000F0F);
        checkOutput("t5_f2_word0", 32'(get_word(bb + 48)), 32'h00001003);
        checkOutput("t5_f2_immediate", 32'(rd_at(rb + 3) - fall_at(fb)), 32'd1);
        checkOutput("t5_latch_width", 32'(latch_hi - lh), 32'd8);
        wait_cycles(200);
        checkOutput("t5_no_third_frame", 32'(latch_rises - lb), 32'd2);
        checkOutput("t5_no_extra_rd", 32'(rd_times.size() - rb), 32'd6);

        // Reset mid-frame at zone 1, bit 7, while SCLK is high
        rsb = rise_times.size();
        applyStimulus(1'b1, 16'h1111, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0);
        applyStimulus(1'b1, 16'h3333, 1'b1);
        k = 0;
        while ((rise_times.size() - rsb < 24) && (k < 400)) begin
            @(negedge clk);
            #1;
            k++;
        end
        checkOutput("t6_reached_bit7", 32'(k < 400), 32'd1);
        checkOutput("t6_zone_before", 32'(zone_cnt), 32'd1);
        checkOutput("t6_sclk_before", 32'(led_sclk), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_reset",
                    32'({fifo_rd_en, led_sclk, led_sdo, led_latch, busy, underrun, zone_cnt}), 32'd0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);
        bb = sdo_bits.size(); lb = latch_rises;
        applyStimulus(1'b1, 16'h4444, 1'b0);
        applyStimulus(1'b1, 16'h5555, 1'b1);
        wait_frame(lb, 1, 600, "t6_frame_done");
        checkOutput("t6_word0", 32'(get_word(bb)), 32'h00003333);
        checkOutput("t6_word1", 32'(get_word(bb + 16)), 32'h00004444);
        checkOutput("t6_word2", 32'(get_word(bb + 32)), 32'h00005555);
        checkOutput("t6_latch_pulses", 32'(latch_rises - lb), 32'd1);

        // Whole-run protocol checks
        checkOutput("sdo_stable_while_sclk_high", 32'(sdo_viol), 32'd0);
        checkOutput("no_rd_en_when_empty", 32'(rd_empty_viol), 32'd0);
        checkOutput("latch_within_busy", 32'(latch_nobusy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
